// File: rtl/kernel_csr_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kernel_csr_irq: Avalon-MM CSR block for kernel launch/done/exception + IRQ |
// | Optional feature macro: KERNEL_CSR_IRQ_COUNT_EN (DONE_COUNT register)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module kernel_csr_irq #(
   parameter int EXC_W = 64
) (
   input  logic             i_clk,
   input  logic             reset_reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   output logic             o_start,
   input  logic             i_done,
   input  logic             i_exc_valid,
   input  logic [EXC_W-1:0] i_exc_data,
   output logic             irq_irq
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [2:0] ADDR_CONTROL = 3'd0;
   localparam logic [2:0] ADDR_STATUS  = 3'd1;
   localparam logic [2:0] ADDR_EXC_LO  = 3'd2;
   localparam logic [2:0] ADDR_EXC_HI  = 3'd3;
   localparam logic [2:0] ADDR_COUNT   = 3'd4;

   state_t           state;
   logic             irq_en;
   logic             done_flag;
   logic             exc_flag;
   logic [EXC_W-1:0] exc_data;
   logic [31:0]      done_count;
   logic [63:0]      exc_ext;
   logic [31:0]      rd_mux;

   logic wr_control;
   logic wr_status;
   logic wr_count;
   logic start_req;
   logic done_accept;
   logic done_clr;
   logic exc_capture;
   logic exc_clr;

   assign wr_control  = avs_write && (avs_address == ADDR_CONTROL);
   assign wr_status   = avs_write && (avs_address == ADDR_STATUS);
   assign wr_count    = avs_write && (avs_address == ADDR_COUNT);
   assign start_req   = wr_control && avs_writedata[0];
   assign done_accept = (state == RUN) && i_done;
   assign done_clr    = wr_status && avs_writedata[1];
   assign exc_capture = i_exc_valid && !exc_flag;
   assign exc_clr     = wr_status && avs_writedata[2];

   // Zero-extend captured data to 64 bits so EXC_HI is a fixed 32-bit slice.
   always_comb begin
      exc_ext = '0;
      exc_ext[EXC_W-1:0] = exc_data;
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_CONTROL: rd_mux = {30'd0, irq_en, 1'b0};
         ADDR_STATUS:  rd_mux = {29'd0, exc_flag, done_flag, (state == RUN)};
         ADDR_EXC_LO:  rd_mux = exc_ext[31:0];
         ADDR_EXC_HI:  rd_mux = exc_ext[63:32];
         ADDR_COUNT:   rd_mux = done_count;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!reset_reset_n) begin
         state             <= IDLE;
         o_start           <= 1'b0;
         irq_en            <= 1'b0;
         done_flag         <= 1'b0;
         exc_flag          <= 1'b0;
         exc_data          <= '0;
         irq_irq           <= 1'b0;
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
      end else begin
         o_start <= 1'b0;
         case (state)
            IDLE: begin
               if (start_req) begin
                  o_start <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (i_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (wr_control) begin
            irq_en <= avs_writedata[1];
         end

         // A set event in the same cycle as its W1C takes priority.
         done_flag <= done_accept || (done_flag && !done_clr);
         exc_flag  <= exc_capture || (exc_flag && !exc_clr);
         if (exc_capture) begin
            exc_data <= i_exc_data;
         end

         irq_irq <= irq_en && (done_flag || exc_flag);

         // rd_mux reflects pre-write state, so a same-cycle write is not visible.
         avs_readdatavalid <= avs_read;
         avs_readdata      <= avs_read ? rd_mux : 32'd0;
      end
   end

`ifdef KERNEL_CSR_IRQ_COUNT_EN
   always_ff @(posedge i_clk) begin
      if (!reset_reset_n) begin
         done_count <= '0;
      end else if (wr_count) begin
         done_count <= '0;
      end else if (done_accept) begin
         done_count <= done_count + 32'd1;
      end
   end
`else
   assign done_count = 32'd0;
   logic unused_count_wr;
   assign unused_count_wr = wr_count;
`endif

   logic unused_wdata;
   assign unused_wdata = &{1'b0, avs_writedata[31:3]};

endmodule
`default_nettype wire

// File: tb/tb_kernel_csr_irq.sv
`default_nettype none
// Scoreboard bench for kernel_csr_irq: driver feeds a flag-level model that
// queues per-cycle expectations; a monitor pops and compares after each edge.
module tb_kernel_csr_irq;

   localparam int EXC_W = 64;

   logic             i_clk = 1'b0;
   logic             reset_reset_n = 1'b0;
   logic [2:0]       avs_address = '0;
   logic             avs_read = 1'b0;
   logic             avs_write = 1'b0;
   logic [31:0]      avs_writedata = '0;
   logic [31:0]      avs_readdata;
   logic             avs_readdatavalid;
   logic             o_start;
   logic             i_done = 1'b0;
   logic             i_exc_valid = 1'b0;
   logic [EXC_W-1:0] i_exc_data = '0;
   logic             irq_irq;

   kernel_csr_irq #(.EXC_W(EXC_W)) dut (
      .i_clk             (i_clk),
      .reset_reset_n     (reset_reset_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .o_start           (o_start),
      .i_done            (i_done),
      .i_exc_valid       (i_exc_valid),
      .i_exc_data        (i_exc_data),
      .irq_irq           (irq_irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          rv;
      logic [31:0] rd;
      bit          st;
      bit          irq;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: kernel busy flag, sticky flags, captured word, counter.
   bit          m_busy, m_done, m_exc, m_irq_en;
   logic [63:0] m_data;
   logic [31:0] m_count;

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return {30'd0, m_irq_en, 1'b0};
         3'd1:    return {29'd0, m_exc, m_done, m_busy};
         3'd2:    return m_data[31:0];
         3'd3:    return m_data[63:32];
         3'd4:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic step(input bit rn, input bit rd, input bit wr, input logic [2:0] a,
                       input logic [31:0] wd, input bit dn, input bit ev,
                       input logic [63:0] ed);
      exp_t e;
      bit   launch, fin, set_exc;
      @(negedge i_clk);
      reset_reset_n = rn;
      avs_read      = rd;
      avs_write     = wr;
      avs_address   = a;
      avs_writedata = wd;
      i_done        = dn;
      i_exc_valid   = ev;
      i_exc_data    = ed;

      e.rv  = rn && rd;
      e.rd  = (rn && rd) ? model_read(a) : 32'd0;
      e.st  = rn && !m_busy && wr && (a == 3'd0) && wd[0];
      e.irq = rn && m_irq_en && (m_done || m_exc);
      sb.push_back(e);

      if (!rn) begin
         m_busy = 0; m_done = 0; m_exc = 0; m_irq_en = 0;
         m_data = '0; m_count = '0;
      end else begin
         launch  = !m_busy && wr && (a == 3'd0) && wd[0];
         fin     = m_busy && dn;
         set_exc = ev && !m_exc;
         m_done  = fin || (m_done && !(wr && a == 3'd1 && wd[1]));
         m_exc   = set_exc || (m_exc && !(wr && a == 3'd1 && wd[2]));
         if (set_exc) m_data = ed;
         if (launch) m_busy = 1;
         else if (fin) m_busy = 0;
         if (wr && a == 3'd0) m_irq_en = wd[1];
`ifdef KERNEL_CSR_IRQ_COUNT_EN
         if (wr && a == 3'd4) m_count = 32'd0;
         else if (fin) m_count = m_count + 32'd1;
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 3'd0, 32'd0, 0, 0, 64'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      step(1, 0, 1, a, d, 0, 0, 64'd0);
   endtask

   task automatic rd(input logic [2:0] a);
      step(1, 1, 0, a, 32'd0, 0, 0, 64'd0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("readdatavalid", {31'd0, avs_readdatavalid}, {31'd0, e.rv});
            chk("readdata", avs_readdata, e.rd);
            chk("o_start", {31'd0, o_start}, {31'd0, e.st});
            chk("irq_irq", {31'd0, irq_irq}, {31'd0, e.irq});
         end
      end
   end

   initial begin : driver
      int budget;
      m_busy = 0; m_done = 0; m_exc = 0; m_irq_en = 0; m_data = '0; m_count = '0;

      // Reset with a read and a write presented; both must be dropped.
      step(0, 1, 1, 3'd0, 32'h3, 0, 0, 64'd0);
      step(0, 0, 0, 3'd0, 32'd0, 0, 0, 64'd0);
      for (int a = 0; a < 8; a++) rd(3'(a));

      // Launch with IRQ_EN, complete, clear.
      wr(3'd0, 32'h3);
      rd(3'd1);
      wr(3'd0, 32'h3);
      rd(3'd1);
      step(1, 0, 0, 3'd0, 32'd0, 1, 0, 64'd0);
      rd(3'd1);
      idle(1);
      step(1, 1, 0, 3'd1, 32'd0, 1, 0, 64'd0);
      rd(3'd4);
      step(1, 1, 1, 3'd1, 32'h2, 0, 0, 64'd0);
      rd(3'd1);
      idle(2);

      // First exception kept; clearing EXC holds the data.
      step(1, 0, 0, 3'd0, 32'd0, 0, 1, 64'h1122_3344_5566_7788);
      step(1, 0, 0, 3'd0, 32'd0, 0, 1, 64'hDEAD_BEEF_0000_0000);
      rd(3'd2); rd(3'd3); rd(3'd1);
      wr(3'd1, 32'h4);
      rd(3'd1); rd(3'd2); rd(3'd3);

      // W1C of DONE in the same cycle as i_done.
      wr(3'd0, 32'h3);
      step(1, 0, 1, 3'd1, 32'h2, 1, 0, 64'd0);
      rd(3'd1);
      idle(2);
      wr(3'd1, 32'h6);

      // Reset mid-RUN, then an i_done that must be ignored.
      wr(3'd0, 32'h3);
      idle(1);
      step(0, 0, 0, 3'd0, 32'd0, 0, 0, 64'd0);
      step(1, 0, 0, 3'd0, 32'd0, 1, 0, 64'd0);
      rd(3'd1); rd(3'd0);
      wr(3'd4, 32'hFFFF_FFFF);
      rd(3'd4); rd(3'd5); wr(3'd6, 32'hFFFF_FFFF); rd(3'd6);

      for (int i = 0; i < 3000; i++) begin
         logic [2:0]  a;
         logic [31:0] d;
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) a = 3'($urandom_range(0, 4));
         d = $urandom();
         if ($urandom_range(0, 1) == 1) d = d & 32'h7;
         step($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, a, d,
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              {$urandom(), $urandom()});
      end
      idle(2);

      budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         @(posedge i_clk);
         budget++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/kernel_csr_irq.md
KERNEL_CSR_IRQ -- requirements
Module: kernel_csr_irq

Interface
REQ-001 Parameter EXC_W, default 64, width of kernel exception data; SHALL be 33..64.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_reset_n  in  1  one clock; reset is synchronous and active-low.
REQ-004 avs_address  in  3  CSR word address.
REQ-005 avs_read / avs_write  in  1 each  Avalon-MM agent read/write strobes.
REQ-006 avs_writedata  in  32  write data; avs_readdata out 32 read data.
REQ-007 avs_readdatavalid  out  1  read response strobe; no waitrequest port (never stalls).
REQ-008 o_start  out  1  one-cycle kernel launch pulse.
REQ-009 i_done  in  1  one-cycle kernel completion pulse.
REQ-010 i_exc_valid  in  1, i_exc_data  in  EXC_W  kernel exception report.
REQ-011 irq_irq  out  1  level interrupt to host.

Function
REQ-012 Register map (word addr): 0 CONTROL, 1 STATUS, 2 EXC_LO, 3 EXC_HI, 4 DONE_COUNT, 5-7 reserved (read 0, writes ignored).
REQ-013 CONTROL: bit0 START write-1 pulse (reads 0); bit1 IRQ_EN read/write; other bits read 0.
REQ-014 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-clear), bit2 EXC (sticky, W1C); other bits read 0.
REQ-015 EXC_LO = captured data[31:0]; EXC_HI = captured data[EXC_W-1:32], zero-extended; both RO.
REQ-016 Read latency exactly 1 cycle: avs_readdatavalid high the cycle after avs_read, avs_readdata valid with it, otherwise readdata 0.
REQ-017 Simultaneous avs_read and avs_write: both performed; read returns pre-write value.
REQ-018 FSM states IDLE, RUN; reset to IDLE; BUSY = (state==RUN).
REQ-019 IDLE + write START=1 -> o_start high next cycle for exactly 1 cycle, state RUN same edge.
REQ-020 RUN + write START=1 -> ignored, no o_start pulse.
REQ-021 RUN + i_done -> IDLE, DONE set; i_done in IDLE ignored (DONE unchanged, counter unchanged).
REQ-022 i_exc_valid while EXC clear -> capture i_exc_data, set EXC; while EXC set -> ignored (first exception kept).
REQ-023 i_exc_valid does not change FSM state.
REQ-024 Set wins over clear: W1C of DONE/EXC in same cycle as its set event leaves bit set (EXC keeps newly captured data).
REQ-025 Clearing EXC does not clear EXC_LO/EXC_HI; they hold until next capture.
REQ-026 irq_irq registered: irq_irq = IRQ_EN & (DONE | EXC), one cycle after the terms change.
REQ-027 Write START=1 and IRQ_EN in same write both take effect.

Reset
REQ-028 reset_reset_n low at a clock edge: state IDLE, IRQ_EN 0, DONE 0, EXC 0, captured data 0, DONE_COUNT 0, o_start 0, irq_irq 0, avs_readdatavalid 0, avs_readdata 0.
REQ-029 Reset while RUN aborts: no o_start, subsequent i_done ignored until new START.
REQ-030 Reads/writes presented during reset are dropped (no readdatavalid afterward).

Configuration
REQ-031 Macro KERNEL_CSR_IRQ_COUNT_EN defined: DONE_COUNT is 32-bit counter incremented on each accepted i_done (REQ-021), wraps 0xFFFFFFFF -> 0, any write to addr 4 clears it (write wins over same-cycle increment).
REQ-032 Macro undefined: no counter logic; addr 4 reads 0, writes ignored.

Verification
REQ-033 Write CONTROL=0x3 -> o_start 1 cycle, STATUS reads 0x1; i_done pulse -> STATUS 0x2, irq_irq 1 one cycle later; write STATUS=0x2 -> STATUS 0x0, irq_irq 0.
REQ-034 RUN, write START again -> no second o_start; i_done in IDLE -> STATUS/DONE_COUNT unchanged.
REQ-035 i_exc_valid with data 0x1122334455667788 then 0xDEADBEEF00000000 -> EXC_LO 0x55667788, EXC_HI 0x11223344, STATUS bit2 set.
REQ-036 W1C of DONE in same cycle as i_done -> DONE remains 1, irq_irq stays 1 (IRQ_EN=1).
REQ-037 COUNT_EN defined: preset counter via 0xFFFFFFFF accepted done cycles or forced, next done -> reads 0x0; undefined -> addr 4 reads 0 always.
REQ-038 Reset asserted mid-RUN -> all outputs 0 next cycle, post-reset i_done leaves STATUS 0x0.
